// File: rtl/lock_pkg.sv
// Shared types and seven-segment glyph table for the combination lock.
package lock_pkg;

  typedef enum logic [2:0] {
    S_ENTRY, S_CHECK, S_OPEN, S_FAIL, S_LOCKOUT
  } state_e;

  // G_0..G_3 are numerically equal to the digit they show.
  typedef enum logic [3:0] {
    G_0, G_1, G_2, G_3, G_DASH, G_BLANK,
    G_O, G_P, G_E, G_N, G_F, G_A, G_I, G_L
  } glyph_e;

  // Active-low, bit0 = segment a .. bit6 = segment g.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_I     = 7'b1111001;
  localparam logic [6:0] SEG_L     = 7'b1000111;

  function automatic logic [6:0] glyph_seg(input glyph_e g);
    case (g)
      G_0:     glyph_seg = SEG_0;
      G_1:     glyph_seg = SEG_1;
      G_2:     glyph_seg = SEG_2;
      G_3:     glyph_seg = SEG_3;
      G_DASH:  glyph_seg = SEG_DASH;
      G_O:     glyph_seg = SEG_O;
      G_P:     glyph_seg = SEG_P;
      G_E:     glyph_seg = SEG_E;
      G_N:     glyph_seg = SEG_N;
      G_F:     glyph_seg = SEG_F;
      G_A:     glyph_seg = SEG_A;
      G_I:     glyph_seg = SEG_I;
      G_L:     glyph_seg = SEG_L;
      default: glyph_seg = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/digital_lock_button_conditioner.sv
// One push button: 2-FF synchronizer, stability debounce, rising-edge pulse.
module button_conditioner #(
  parameter logic [15:0] DEB_CYC = 16'd50000
) (
  input  logic clk,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  logic [1:0]  sync_q;
  logic [15:0] cnt_q, cnt_d;
  logic        deb_q, deb_d;
  logic        prev_q;

  // The counter tracks how many consecutive samples disagree with the accepted level.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync_q[1] != deb_q) begin
      if (cnt_q >= DEB_CYC - 16'd1) deb_d = sync_q[1];
      else                          cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      sync_q <= '0;
      cnt_q  <= '0;
      deb_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
      prev_q <= deb_q;
    end
  end

  assign level_o = deb_q;
  assign rise_o  = deb_q & ~prev_q;

endmodule

// File: rtl/digital_lock_top.sv
// 4-button combination lock: entry FSM, fail/lockout timers, LED and 7-seg display.
module digital_lock_top
  import lock_pkg::*;
#(
  parameter logic [7:0]  CODE        = 8'b00_01_10_11,
  parameter logic [15:0] DEB_CYC     = 16'd50000,
  parameter int          SCAN_DIV    = 16,
  parameter logic [23:0] FAIL_CYC    = 24'd5000000,
  parameter int          MAX_TRIES   = 3,
  parameter logic [27:0] LOCKOUT_CYC = 28'd100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] button,
  output logic [6:0] ssd,
  output logic [3:0] led,
  output logic [3:0] dig
);

  localparam logic [7:0] MAX_T = 8'(MAX_TRIES);

  logic [3:0] lvl, rise;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_conditioner #(.DEB_CYC(DEB_CYC)) u_cond (
      .clk     (clk),
      .rst_i   (rst_n),
      .btn_i   (button[i]),
      .level_o (lvl[i]),
      .rise_o  (rise[i])
    );
  end

  // Only a lone button going down counts; chords and partial releases are ignored.
  logic       press;
  logic [1:0] press_digit;
  assign press = (rise != 4'b0000) && (rise == lvl) && $onehot(lvl);

  always_comb begin
    press_digit = 2'd0;
    case (rise)
      4'b0010: press_digit = 2'd1;
      4'b0100: press_digit = 2'd2;
      4'b1000: press_digit = 2'd3;
      default: press_digit = 2'd0;
    endcase
  end

  state_e              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          ent_q, ent_d;
  logic [7:0]          fails_q, fails_d, fails_inc;
  logic [27:0]         tmr_q, tmr_d;
  logic [SCAN_DIV-1:0] scan_q;

  assign fails_inc = fails_q + 8'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ent_d   = ent_q;
    fails_d = fails_q;
    tmr_d   = tmr_q;
    case (state_q)
      S_ENTRY: if (press) begin
        case (idx_q[1:0])
          2'd0:    ent_d[7:6] = press_digit;
          2'd1:    ent_d[5:4] = press_digit;
          2'd2:    ent_d[3:2] = press_digit;
          default: ent_d[1:0] = press_digit;
        endcase
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd3) state_d = S_CHECK;
      end
      S_CHECK: begin
        tmr_d = '0;
        if (ent_q == CODE) begin
          state_d = S_OPEN;
          fails_d = '0;
        end else begin
          fails_d = fails_inc;
          state_d = (fails_inc >= MAX_T) ? S_LOCKOUT : S_FAIL;
        end
      end
      S_OPEN: if (press) begin
        state_d = S_ENTRY;
        idx_d   = '0;
      end
      S_FAIL: begin
        if (tmr_q == {4'd0, FAIL_CYC} - 28'd1) begin
          state_d = S_ENTRY;
          idx_d   = '0;
        end else tmr_d = tmr_q + 28'd1;
      end
      S_LOCKOUT: begin
        if (tmr_q == LOCKOUT_CYC - 28'd1) begin
          state_d = S_ENTRY;
          idx_d   = '0;
          fails_d = '0;
        end else tmr_d = tmr_q + 28'd1;
      end
      default: state_d = S_ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= S_ENTRY;
      idx_q   <= '0;
      ent_q   <= '0;
      fails_q <= '0;
      tmr_q   <= '0;
      scan_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ent_q   <= ent_d;
      fails_q <= fails_d;
      tmr_q   <= tmr_d;
      scan_q  <= scan_q + SCAN_DIV'(1);
    end
  end

  always_comb begin
    case (state_q)
      S_OPEN:    led = 4'b0010;
      S_FAIL:    led = 4'b0100;
      S_LOCKOUT: led = 4'b1000;
      default:   led = 4'b0001;
    endcase
  end

  logic [1:0] scan, slot, slot_dig;
  glyph_e     g;
  assign scan = scan_q[SCAN_DIV-1 -: 2];
  assign slot = 2'd3 - scan;
  assign dig  = ~(4'b0001 << scan);

  always_comb begin
    case (slot)
      2'd0:    slot_dig = ent_q[7:6];
      2'd1:    slot_dig = ent_q[5:4];
      2'd2:    slot_dig = ent_q[3:2];
      default: slot_dig = ent_q[1:0];
    endcase
  end

  // Leftmost position shows slot 0 (first digit entered).
  always_comb begin
    g = G_DASH;
    case (state_q)
      S_OPEN: case (scan)
        2'd3:    g = G_O;
        2'd2:    g = G_P;
        2'd1:    g = G_E;
        default: g = G_N;
      endcase
      S_FAIL: case (scan)
        2'd3:    g = G_F;
        2'd2:    g = G_A;
        2'd1:    g = G_I;
        default: g = G_L;
      endcase
      S_LOCKOUT: g = G_BLANK;
      default: if ({1'b0, slot} < idx_q) g = glyph_e'({2'b00, slot_dig});
    endcase
  end

  assign ssd = glyph_seg(g);

endmodule

// File: tb/tb_digital_lock_top.sv
// Directed bench for digital_lock_top with a display scoreboard.
module tb_digital_lock_top;

  localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100, D3 = 7'b0110000;
  localparam logic [6:0] DSH = 7'b0111111;
  localparam logic [6:0] CO = 7'b1000000, CP = 7'b0001100, CE = 7'b0000110, CN = 7'b0101011;
  localparam logic [6:0] CF = 7'b0001110, CA = 7'b0001000, CI = 7'b1111001, CL = 7'b1000111;
  localparam logic [3:0][6:0] DASHES = {DSH, DSH, DSH, DSH};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] button;
  logic [6:0] ssd;
  logic [3:0] led;
  logic [3:0] dig;

  always #5 clk = ~clk;

  digital_lock_top #(
    .CODE(8'b00_01_10_11), .DEB_CYC(16'd2), .SCAN_DIV(4),
    .FAIL_CYC(24'd8), .MAX_TRIES(3), .LOCKOUT_CYC(28'd32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .button(button), .ssd(ssd), .led(led), .dig(dig)
  );

  int checks = 0;
  int errors = 0;

  // Cycles since reset release; its top two bits select the lit position.
  logic [3:0] bcnt;
  always @(posedge clk) begin
    if (rst_n) bcnt <= 4'd0;
    else       bcnt <= bcnt + 4'd1;
  end

  typedef struct {
    string           tag;
    logic [3:0][6:0] seg;
  } disp_t;
  disp_t sb[$];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp_now(input string tag, input logic [3:0][6:0] e);
    logic [1:0] pos;
    logic [3:0] edig;
    pos  = bcnt[3:2];
    edig = ~(4'b0001 << pos);
    chk({tag, "_dig"}, {28'd0, dig}, {28'd0, edig});
    chk({tag, "_ssd"}, {25'd0, ssd}, {25'd0, e[pos]});
  endtask

  task automatic expect_disp(input string tag, input logic [3:0][6:0] e);
    disp_t d;
    d.tag = tag;
    d.seg = e;
    sb.push_back(d);
  endtask

  task automatic pop_disp(output disp_t d);
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL sb_pop: observed empty queue expected an entry");
    end
    if (sb.size() > 0) d = sb.pop_front();
    else begin
      d.tag = "none";
      d.seg = DASHES;
    end
  endtask

  task automatic check_disp();
    disp_t d;
    pop_disp(d);
    repeat (16) begin
      chk_disp_now(d.tag, d.seg);
      step();
    end
  endtask

  task automatic press(input int b);
    button = 4'b0001 << b;
    hold(8);
    button = 4'b0000;
    hold(8);
  endtask

  initial begin
    disp_t d;
    rst_n  = 1'b1;
    button = 4'b0000;

    // Reset state
    hold(3);
    chk("rst_led", {28'd0, led}, 32'b0001);
    chk("rst_dig", {28'd0, dig}, 32'b1110);
    chk("rst_ssd", {25'd0, ssd}, {25'd0, DSH});
    rst_n = 1'b0;

    // Correct code opens; any press relocks without storing a digit
    press(0); press(1); press(2);
    button = 4'b1000;
    hold(6);
    chk("open_led", {28'd0, led}, 32'b0010);
    hold(2);
    button = 4'b0000;
    hold(8);
    expect_disp("open", {CO, CP, CE, CN});
    check_disp();
    press(3);
    chk("open_exit_led", {28'd0, led}, 32'b0001);
    expect_disp("open_exit", DASHES);
    check_disp();

    // Wrong code: FAIL for exactly 8 cycles
    press(0); press(0); press(0);
    button = 4'b0001;
    hold(6);
    expect_disp("fail", {CF, CA, CI, CL});
    pop_disp(d);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) button = 4'b0000;
      chk("fail_led", {28'd0, led}, 32'b0100);
      chk_disp_now(d.tag, d.seg);
      step();
    end
    chk("fail_end_led", {28'd0, led}, 32'b0001);
    hold(2);
    expect_disp("fail_exit", DASHES);
    check_disp();

    // Three consecutive failures from a clean fail count -> lockout
    rst_n = 1'b1;
    hold(2);
    rst_n = 1'b0;
    press(0); press(0); press(0); press(0);
    chk("try1_led", {28'd0, led}, 32'b0001);
    press(0); press(0); press(0);
    button = 4'b0001;
    hold(6);
    chk("try2_fail_led", {28'd0, led}, 32'b0100);
    hold(2);
    button = 4'b0000;
    hold(8);
    press(0); press(0); press(0);
    button = 4'b0001;
    hold(6);
    for (int i = 0; i < 32; i++) begin
      if (i == 2)  button = 4'b0000;
      if (i == 10) button = 4'b0010;
      if (i == 18) button = 4'b0000;
      chk("lock_led", {28'd0, led}, 32'b1000);
      step();
    end
    chk("lock_end_led", {28'd0, led}, 32'b0001);
    expect_disp("lock_exit", DASHES);
    check_disp();
    press(0); press(1); press(2); press(3);
    chk("relock_open_led", {28'd0, led}, 32'b0010);
    press(0);
    chk("relock_exit_led", {28'd0, led}, 32'b0001);

    // Glitches: single-cycle pulse and a two-button chord store nothing
    button = 4'b0001;
    step();
    button = 4'b0000;
    hold(8);
    button = 4'b0011;
    hold(8);
    button = 4'b0000;
    hold(8);
    chk("glitch_led", {28'd0, led}, 32'b0001);
    expect_disp("glitch", DASHES);
    check_disp();

    // Partial entry display, then reset mid-entry
    press(2); press(1);
    expect_disp("partial", {D2, D1, DSH, DSH});
    check_disp();
    rst_n = 1'b1;
    step();
    chk("midrst_dig", {28'd0, dig}, 32'b1110);
    chk("midrst_ssd", {25'd0, ssd}, {25'd0, DSH});
    step();
    rst_n = 1'b0;
    chk("midrst_led", {28'd0, led}, 32'b0001);
    expect_disp("midrst", DASHES);
    check_disp();
    press(3);
    expect_disp("after_rst", {D3, DSH, DSH, DSH});
    check_disp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
